// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one XOR/AND bit-cell per clock, LSB first, carry flop closes the loop.
// Optional subtract mode (a + ~b + 1) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic         sub_i,
`endif
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] s_o,
    output logic         cout_o
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  ra_q, ra_d;
    logic [N-1:0]  rb_q, rb_d;
    logic [N-1:0]  rs_q, rs_d;
    logic [N-1:0]  s_q, s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          c_q, c_d;
    logic          cout_q, cout_d;
    logic          sub_w;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_w = sub_i;
`else
    assign sub_w = 1'b0;
`endif

    // Full-adder bit step built from two half-adder cells plus an OR.
    logic ha0_s, ha0_c, ha1_s, ha1_c, sbit, c_nx;
    assign ha0_s = ra_q[0] ^ rb_q[0];
    assign ha0_c = ra_q[0] & rb_q[0];
    assign ha1_s = ha0_s ^ c_q;
    assign ha1_c = ha0_s & c_q;
    assign sbit  = ha1_s;
    assign c_nx  = ha0_c | ha1_c;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rs_q    <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rs_q    <= rs_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rs_d    = rs_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    ra_d    = a_i;
                    rb_d    = sub_w ? ~b_i : b_i;
                    c_d     = sub_w;
                    rs_d    = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                c_d   = c_nx;
                rs_d  = {sbit, rs_q[N-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    s_d     = {sbit, rs_q[N-1:1]};
                    cout_d  = c_nx;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q == RUN);
    assign done_o = (state_q == DONE);
    assign s_o    = s_q;
    assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: a cycle-level model pushes expected results on
// accepting edges; a negedge monitor pops and compares on every done pulse.
module tb_serial_adder;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i = 1'b0;
    logic [N-1:0] a_i = '0;
    logic [N-1:0] b_i = '0;
    logic         sub_t = 1'b0;
    logic         busy_o, done_o, cout_o;
    logic [N-1:0] s_o;

    serial_adder #(.N(N)) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .start_i(start_i),
        .a_i    (a_i),
        .b_i    (b_i),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i  (sub_t),
`endif
        .busy_o (busy_o),
        .done_o (done_o),
        .s_o    (s_o),
        .cout_o (cout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] s;
        logic         c;
        int           e;
    } exp_t;

    exp_t exp_q[$];

    // Model state: edge counter, the last accepted operation and the held outputs.
    int           ecnt = 0;
    int           avail = 0;
    bit           acc_valid = 0;
    int           acc_e = 0;
    logic [N-1:0] cur_s = '0;
    logic         cur_c = 1'b0;
    logic [N-1:0] hold_s = '0;
    logic         hold_c = 1'b0;
    bit           fin = 0;

    int total = 0;
    int bad = 0;

    function automatic exp_t ref_op(input logic [N-1:0] a, input logic [N-1:0] b,
                                    input logic sub, input int e);
        exp_t r;
        int unsigned ai, bi, sum;
        ai = int'(a);
        bi = int'(b);
        if (sub) begin
            r.s = N'(ai - bi);
            r.c = (ai >= bi);
        end else begin
            sum = ai + bi;
            r.s = N'(sum);
            r.c = (sum >= (1 << N));
        end
        r.e = e;
        return r;
    endfunction

    always @(posedge clk) begin
        exp_t x;
        ecnt = ecnt + 1;
        if (rst_i) begin
            acc_valid = 0;
            hold_s    = '0;
            hold_c    = 1'b0;
            avail     = ecnt + 1;
        end else begin
            if (acc_valid && ecnt == acc_e + N) begin
                hold_s = cur_s;
                hold_c = cur_c;
            end
            if (start_i && ecnt >= avail) begin
                x         = ref_op(a_i, b_i, sub_t, ecnt);
                acc_valid = 1;
                acc_e     = ecnt;
                cur_s     = x.s;
                cur_c     = x.c;
                avail     = ecnt + N + 1;
                exp_q.push_back(x);
            end
        end
    end

    always @(negedge clk) begin
        exp_t     e;
        logic     xb, xd;
        if (fin) begin
            total++;
            if (exp_q.size() != 0) begin
                bad++;
                $display("FAIL drain: pending results=%0d required=0", exp_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end else if (ecnt >= 1) begin
            xb = acc_valid && ecnt >= acc_e && ecnt < acc_e + N;
            xd = acc_valid && ecnt == acc_e + N;
            total++;
            if (busy_o !== xb) begin
                bad++;
                $display("FAIL busy @edge%0d: got=%b required=%b", ecnt, busy_o, xb);
            end
            total++;
            if (done_o !== xd) begin
                bad++;
                $display("FAIL done @edge%0d: got=%b required=%b", ecnt, done_o, xd);
            end
            total++;
            if (s_o !== hold_s || cout_o !== hold_c) begin
                bad++;
                $display("FAIL hold @edge%0d: got s=%h c=%b required s=%h c=%b",
                         ecnt, s_o, cout_o, hold_s, hold_c);
            end
            if (done_o === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL result @edge%0d: unexpected done, none pending", ecnt);
                end else begin
                    e = exp_q.pop_front();
                    if (s_o !== e.s || cout_o !== e.c || ecnt - e.e != N) begin
                        bad++;
                        $display("FAIL result @edge%0d: got s=%h c=%b lat=%0d required s=%h c=%b lat=%0d",
                                 ecnt, s_o, cout_o, ecnt - e.e, e.s, e.c, N);
                    end
                end
            end
            if (rst_i) exp_q.delete();
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
        start_i = 1'b1;
        a_i     = a;
        b_i     = b;
        sub_t   = sub;
        tick();
        start_i = 1'b0;
        a_i     = ~a;
        b_i     = ~b;
        tick(N + 2);
    endtask

    initial begin
        // Reset held with start asserted.
        rst_i   = 1'b1;
        start_i = 1'b1;
        a_i     = 8'hA5;
        b_i     = 8'h5A;
        tick(2);
        rst_i   = 1'b0;
        start_i = 1'b0;
        tick(2);

        go(8'h5A, 8'h3C, 1'b0);
        go(8'hFF, 8'h01, 1'b0);
        go(8'hFF, 8'hFF, 1'b0);
        go(8'h00, 8'h00, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
        go(8'd5, 8'd3, 1'b1);
        go(8'd3, 8'd5, 1'b1);
        go(8'd3, 8'd5, 1'b0);
        go(8'h80, 8'h80, 1'b1);
`endif

        // Start held high with operands changing every cycle.
        for (int i = 0; i < 6 * (N + 1); i++) begin
            start_i = 1'b1;
            a_i     = N'($urandom);
            b_i     = N'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            sub_t   = 1'($urandom);
`endif
            tick();
        end
        start_i = 1'b0;
        sub_t   = 1'b0;
        tick(N + 2);

        // Reset during the 4th RUN cycle aborts the operation.
        start_i = 1'b1;
        a_i     = 8'h12;
        b_i     = 8'h34;
        tick();
        start_i = 1'b0;
        tick(3);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick(2);
        go(8'h01, 8'h02, 1'b0);

        // Random operations with random idle gaps.
        for (int i = 0; i < 30; i++) begin
            logic sb;
            sb = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sb = 1'($urandom);
`endif
            start_i = 1'b1;
            a_i     = N'($urandom);
            b_i     = N'($urandom);
            sub_t   = sb;
            tick();
            start_i = 1'b0;
            tick(N + int'($urandom_range(0, 3)));
        end

        tick(N + 3);
        fin = 1;
        tick(3);
        $display("FAIL finish: monitor did not end the run");
        $fatal(1);
    end

endmodule
